output_route_ctrl: RTL
======================

Name: output_route_ctrl

Overview:
Sequences delivery of one layer's result words from the PE array to either the main buffer (fully-connected/convolution mode) or the max-pooling unit (pooling mode). Latches a per-layer mode and word count, drives the 1-to-2 steering select, and runs a valid/ready handshake on the input and on both destinations. Counts transferred words and pulses done when the layer is complete. Sits between the PE-array result stream and the main-buffer / max-pooling write ports.

Parameters:
DATA_WIDTH, 32, result word width
CNT_WIDTH, 16, width of the layer word count
FULLY_CONVOL, 1'b0, select encoding that routes to the main buffer
POOLING, 1'b1, select encoding that routes to max pooling

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  start a layer; sampled only in IDLE
cfg_mode  in  1  FULLY_CONVOL or POOLING; latched on accepted cfg_start
cfg_len  in  CNT_WIDTH  number of words in the layer; latched on accepted cfg_start
cfg_abort  in  1  synchronous abort of the current layer
cfg_idle  out  1  high in IDLE (ready for cfg_start)
in_valid  in  1  PE result word valid
in_data  in  DATA_WIDTH  PE result word
in_ready  out  1  controller accepts in_data this cycle
sel  out  1  steering select, held at the latched mode
route_data  out  DATA_WIDTH  registered output word, common to both destinations
buf_valid  out  1  word valid toward main buffer
buf_ready  in  1  main buffer accepts
pool_valid  out  1  word valid toward max pooling
pool_ready  in  1  max pooling accepts
word_cnt  out  CNT_WIDTH  words delivered to the destination in the current layer
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at layer completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=FULLY_CONVOL, route_data=0, buf_valid=pool_valid=0, in_ready=0, word_cnt=0, done=0, busy=0, cfg_idle=1. All internal counters and latched config cleared.
- FSM: IDLE -> ROUTE on cfg_start with cfg_len!=0; IDLE -> DONE on cfg_start with cfg_len==0. ROUTE -> DRAIN when the last word (accepted count==len) is accepted. DRAIN -> DONE when the output register empties. DONE -> IDLE unconditionally after 1 cycle, with done=1 during DONE only.
- cfg_start outside IDLE is ignored. sel changes only on an accepted cfg_start and is otherwise stable through ROUTE/DRAIN/DONE.
- Output register: one entry (out_valid, route_data). dest_ready = (sel==POOLING) ? pool_ready : buf_ready. buf_valid = out_valid & (sel==FULLY_CONVOL); pool_valid = out_valid & (sel==POOLING). The deselected valid is always 0. route_data holds its value while valid and not ready.
- in_ready = (state==ROUTE) & (accepted<len) & (!out_valid | dest_ready). Combinational from dest_ready. No path from in_valid.
- Input accept (in_valid & in_ready): route_data<=in_data and out_valid<=1 on the next edge. Latency is 1 cycle. Throughput is 1 word/cycle under continuous ready.
- Output transfer (out_valid & dest_ready): word_cnt increments. Without a simultaneous accept, out_valid<=0.
- word_cnt is cleared on an accepted cfg_start and holds its final value after DONE until the next start.
- cfg_abort (any state other than IDLE): next cycle state=IDLE, out_valid=0, no done pulse. word_cnt holds. Abort has priority over every other event in the same cycle.
- Boundary: cfg_len=max (2^CNT_WIDTH-1) is supported and counters must not wrap. The opposite destination's ready is ignored. Reset mid-layer behaves exactly as the reset values above.

Decomposition:
- Package output_route_pkg: state enum (IDLE, ROUTE, DRAIN, DONE), route select constants FULLY_CONVOL/POOLING, default widths.
- One natural sub-module, route_out_slice: the single-entry valid/ready register holding route_data/out_valid. The FSM and counters stay in the top module.

Test Plan:
- Reset then cfg_start, mode=FULLY_CONVOL, len=4, in_valid=1 with data 0x11..0x14, buf_ready=1 -> buf_valid 4 consecutive cycles starting 1 cycle after first accept, pool_valid=0 throughout, word_cnt=4, done pulses once, then cfg_idle=1.
- mode=POOLING, len=3, pool_ready toggling 1,0,0,1,... -> route_data stable while stalled, in_ready=0 during stall, words arrive in order, sel=1 throughout, done after the 3rd transfer.
- cfg_len=0 start -> DONE the next cycle, done=1 for one cycle, in_ready never asserted, word_cnt=0.
- cfg_start pulsed mid-layer with a different mode and len -> ignored: sel, len, and count are unchanged and the layer completes normally.
- cfg_abort after 2 of 5 words, with a word pending in the output register -> next cycle IDLE, buf_valid=0, no done, word_cnt=2. A new start then runs cleanly.
- rst_n asserted asynchronously mid-ROUTE (between clock edges) -> all outputs take reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/output_route_pkg.sv
// Shared types and constants for the PE-result output router.
package output_route_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  localparam logic SEL_FULLY_CONVOL = 1'b0;
  localparam logic SEL_POOLING      = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } route_state_e;

endpackage

// File: rtl/route_out_slice.sv
// Single-entry valid/ready output register shared by both destinations.
module route_out_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  take,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Flush wins; a load in the same cycle as a take refills the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/output_route_ctrl.sv
// Steers one layer of PE result words to the main buffer or max-pooling unit,
// counting delivered words and pulsing done at layer completion.
module output_route_ctrl
  import output_route_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter logic        FULLY_CONVOL = SEL_FULLY_CONVOL,
  parameter logic        POOLING      = SEL_POOLING
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_abort,
  output logic                  cfg_idle,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] route_data,
  output logic                  buf_valid,
  input  logic                  buf_ready,
  output logic                  pool_valid,
  input  logic                  pool_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy,
  output logic                  done
);

  route_state_e         state_q, state_d;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] acc_inc;
  logic                 out_valid;
  logic                 dest_ready;
  logic                 accept;
  logic                 xfer;
  logic                 start_ok;
  logic                 abort_ok;

  assign dest_ready = (mode_q == POOLING) ? pool_ready : buf_ready;
  assign acc_inc    = acc_q + CNT_WIDTH'(1);
  assign accept     = in_valid & in_ready;
  assign xfer       = out_valid & dest_ready;
  assign start_ok   = (state_q == IDLE) & cfg_start;
  assign abort_ok   = (state_q != IDLE) & cfg_abort;

  assign sel        = mode_q;
  assign buf_valid  = out_valid & (mode_q == FULLY_CONVOL);
  assign pool_valid = out_valid & (mode_q == POOLING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded outputs; abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    cfg_idle = 1'b0;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        cfg_idle = 1'b1;
        if (cfg_start) state_d = (cfg_len != '0) ? ROUTE : DONE;
      end
      ROUTE: begin
        in_ready = (acc_q < len_q) & (!out_valid | dest_ready);
        if (accept && (acc_inc == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || dest_ready) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_ok) state_d = IDLE;
  end

  // Layer config and counters; cleared only by reset or an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= FULLY_CONVOL;
      len_q    <= '0;
      acc_q    <= '0;
      word_cnt <= '0;
    end else if (start_ok) begin
      mode_q   <= cfg_mode;
      len_q    <= cfg_len;
      acc_q    <= '0;
      word_cnt <= '0;
    end else if (!abort_ok) begin
      if (accept) acc_q    <= acc_inc;
      if (xfer)   word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

  route_out_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_ok),
    .load      (accept),
    .load_data (in_data),
    .take      (xfer),
    .out_valid (out_valid),
    .out_data  (route_data)
  );

endmodule
